// File: rtl/lif_neuron_b2leak.sv
// rtl/lif_neuron_b2leak.sv - leaky integrate-and-fire neuron with base-2 shift leak
// Integrates weight on pre_spike, leaks by v>>LEAK_SHIFT every LEAK_PERIOD cycles, fires at THRESHOLD.
module lif_neuron_b2leak #(
  parameter int W_WIDTH        = 16,
  parameter int V_WIDTH        = 20,
  parameter int THRESHOLD      = 4096,
  parameter int LEAK_SHIFT     = 4,
  parameter int LEAK_PERIOD    = 8,
  parameter int REFRACT_CYCLES = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pre_spike,
  input  logic [W_WIDTH-1:0] weight,
  output logic               post_spike,
  output logic [V_WIDTH-1:0] membrane,
  output logic               in_refractory,
  output logic [7:0]         spike_count
);

  localparam int LC_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int RC_W = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;
  localparam logic [LC_W-1:0]    LEAK_LAST = LC_W'(LEAK_PERIOD - 1);
  localparam logic [RC_W-1:0]    RC_LOAD   = RC_W'(REFRACT_CYCLES - 1);
  localparam logic [V_WIDTH:0]   THR       = (V_WIDTH + 1)'(THRESHOLD);
  localparam logic [V_WIDTH:0]   V_MAX     = {1'b0, {V_WIDTH{1'b1}}};

  typedef enum logic {ST_INTEGRATE, ST_REFRACTORY} state_t;

  state_t             state_q, state_d;
  logic [V_WIDTH-1:0] v_q, v_d;
  logic               post_q, post_d;
  logic               inref_q, inref_d;
  logic [RC_W-1:0]    refr_q, refr_d;
  logic [LC_W-1:0]    leak_q, leak_d;
  logic [7:0]         cnt_q, cnt_d;

  logic               leak_tick;
  logic [V_WIDTH-1:0] v_l;
  logic [V_WIDTH:0]   v_sum, v_a;

  always_comb begin
    leak_tick = (leak_q == LEAK_LAST);
    leak_d    = leak_tick ? '0 : leak_q + LC_W'(1);

    // Leak is applied before the add; one extra bit catches overflow for saturation.
    v_l   = leak_tick ? v_q - (v_q >> LEAK_SHIFT) : v_q;
    v_sum = {1'b0, v_l} + (pre_spike ? (V_WIDTH + 1)'(weight) : '0);
    v_a   = (v_sum > V_MAX) ? V_MAX : v_sum;

    state_d = state_q;
    v_d     = v_q;
    post_d  = 1'b0;
    refr_d  = refr_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_INTEGRATE: begin
        if (v_a >= THR) begin
          v_d     = '0;
          post_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          refr_d  = RC_LOAD;
          state_d = ST_REFRACTORY;
        end else begin
          v_d = v_a[V_WIDTH-1:0];
        end
      end
      ST_REFRACTORY: begin
        v_d = '0;
        if (refr_q == '0) begin
          state_d = ST_INTEGRATE;
        end else begin
          refr_d = refr_q - RC_W'(1);
        end
      end
      default: state_d = ST_INTEGRATE;
    endcase

    inref_d = (state_d == ST_REFRACTORY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INTEGRATE;
      v_q     <= '0;
      post_q  <= 1'b0;
      inref_q <= 1'b0;
      refr_q  <= '0;
      leak_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      post_q  <= post_d;
      inref_q <= inref_d;
      refr_q  <= refr_d;
      leak_q  <= leak_d;
      cnt_q   <= cnt_d;
    end
  end

  assign post_spike    = post_q;
  assign membrane      = v_q;
  assign in_refractory = inref_q;
  assign spike_count   = cnt_q;

endmodule

// File: tb/tb_lif_neuron_b2leak.sv
// tb/tb_lif_neuron_b2leak.sv - self-checking bench for lif_neuron_b2leak
// Two instances: default parameters, and a max-threshold / slow-leak one for saturation.
module tb_lif_neuron_b2leak;

  localparam int TH  = 4096;
  localparam int LP  = 8;
  localparam int RC  = 5;
  localparam int TH2 = 20'hFFFFF;
  localparam int LP2 = 64;
  localparam int VMAX = 1048575;

  logic        clk = 1'b0;
  logic        rst, pre, rst2, pre2;
  logic [15:0] w, w2;
  logic        post1, post2, inr1, inr2;
  logic [19:0] mem1, mem2;
  logic [7:0]  cnt1, cnt2;

  always #5 clk = ~clk;

  lif_neuron_b2leak dut (
    .clk(clk), .rst(rst), .pre_spike(pre), .weight(w),
    .post_spike(post1), .membrane(mem1), .in_refractory(inr1), .spike_count(cnt1)
  );

  lif_neuron_b2leak #(.THRESHOLD(TH2), .LEAK_PERIOD(LP2)) dut2 (
    .clk(clk), .rst(rst2), .pre_spike(pre2), .weight(w2),
    .post_spike(post2), .membrane(mem2), .in_refractory(inr2), .spike_count(cnt2)
  );

  typedef struct {
    int v;
    int refr;
    int cyc;
    int cnt;
    bit post;
  } mdl_t;

  mdl_t m1, m2;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // refr = remaining edges in which input is ignored; cyc = edges since reset.
  function automatic mdl_t step(mdl_t m, bit r, bit p, int wt, int th, int lp);
    mdl_t n;
    int   v;
    n = m;
    if (r) begin
      n.v = 0; n.refr = 0; n.cyc = 0; n.cnt = 0; n.post = 0;
      return n;
    end
    n.cyc  = m.cyc + 1;
    n.post = 0;
    if (m.refr > 0) begin
      n.refr = m.refr - 1;
      n.v    = 0;
    end else begin
      v = m.v;
      if ((m.cyc % lp) == lp - 1) v = v - v / 16;
      if (p) v = v + wt;
      if (v > VMAX) v = VMAX;
      if (v >= th) begin
        n.v = 0; n.post = 1; n.cnt = (m.cnt + 1) % 256; n.refr = RC;
      end else begin
        n.v = v;
      end
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    m1 = step(m1, rst, pre, int'(w), TH, LP);
    m2 = step(m2, rst2, pre2, int'(w2), TH2, LP2);
    @(negedge clk);
    check("mem1", mem1, m1.v);
    check("post1", post1, m1.post);
    check("inr1", inr1, m1.refr > 0);
    check("cnt1", cnt1, m1.cnt);
    check("mem2", mem2, m2.v);
    check("post2", post2, m2.post);
    check("inr2", inr2, m2.refr > 0);
    check("cnt2", cnt2, m2.cnt);
  endtask

  task automatic drive(input bit r, input bit p, input int wt);
    rst = r; pre = p; w = 16'(wt);
    tick();
  endtask

  initial begin
    m1 = '{default: 0};
    m2 = '{default: 0};
    rst = 1; pre = 1; w = 16'd1000;
    rst2 = 1; pre2 = 0; w2 = '0;
    @(negedge clk);

    // Reset with input active
    drive(1, 1, 1000);
    drive(1, 1, 1000);
    check("rst_mem", mem1, 0);
    check("rst_post", post1, 0);
    check("rst_cnt", cnt1, 0);

    // Sub-threshold add on a non-tick edge (first edge after reset has leak_cnt=0)
    drive(0, 1, 1000);
    check("sub_mem", mem1, 1000);
    check("sub_post", post1, 0);

    // Fire and refractory
    drive(1, 0, 0);
    drive(0, 1, 5000);
    check("fire_post", post1, 1);
    check("fire_mem", mem1, 0);
    check("fire_inr", inr1, 1);
    for (int i = 0; i < RC; i++) begin
      drive(0, 1, 5000);
      check("refr_post", post1, 0);
      check("refr_mem", mem1, 0);
      check("refr_inr", inr1, i < RC - 1);
    end
    drive(0, 1, 1000);
    check("after_refr_mem", mem1, 1000);

    // Leak: load 1600 on a non-tick edge, then two leak periods
    drive(1, 0, 0);
    drive(0, 1, 1600);
    check("leak_load", mem1, 1600);
    for (int i = 0; i < LP; i++) drive(0, 0, 0);
    check("leak1", mem1, 1500);
    for (int i = 0; i < LP; i++) drive(0, 0, 0);
    check("leak2", mem1, 1407);
    drive(1, 0, 0);
    drive(0, 1, 15);
    for (int i = 0; i < 2 * LP; i++) drive(0, 0, 0);
    check("leak_floor", mem1, 15);

    // Saturation on the max-threshold instance
    rst2 = 0; pre2 = 1; w2 = 16'hFFFF;
    for (int i = 0; i < 16; i++) drive(0, 0, 0);
    check("sat_16", mem2, 16 * 65535);
    check("sat_16_post", post2, 0);
    drive(0, 0, 0);
    check("sat_fire", post2, 1);
    check("sat_mem", mem2, 0);
    check("sat_cnt", cnt2, 1);
    pre2 = 0;

    // Reset mid-refractory
    drive(1, 0, 0);
    drive(0, 1, 5000);
    drive(0, 0, 0);
    drive(1, 0, 0);
    check("midrst_inr", inr1, 0);
    check("midrst_cnt", cnt1, 0);
    drive(0, 1, 500);
    check("midrst_mem", mem1, 500);

    // Spike counter wrap: fire every RC+1 cycles
    drive(1, 0, 0);
    for (int i = 0; i < 260 * (RC + 1); i++) drive(0, 1, 5000);
    check("wrap_cnt", cnt1, 4);

    // Randomized traffic on both instances
    for (int i = 0; i < 4000; i++) begin
      rst2 = ($urandom_range(0, 999) == 0);
      pre2 = $urandom_range(0, 1);
      w2   = 16'($urandom);
      drive($urandom_range(0, 1499) == 0, $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0) ? $urandom_range(3000, 65535) : $urandom_range(0, 1200));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
